rgb_pwm_sequencer: RTL and testbench
====================================

# rgb_pwm_sequencer

Parametrised multi-channel LED PWM sequencer for the iCE40 LED path. It is clocked from the internal oscillator net and generates one PWM output per channel. Each channel independently runs OFF, STATIC, BLINK or BREATHE, replacing the free-running counter with a configurable brightness/pattern engine. Its `pwm_out` bits drive the `RGBnPWM` inputs of the RGB driver primitive.

## Interface
- `CHANNELS`, 3: number of PWM channels (1..8).
- `PWM_BITS`, 8: PWM counter/duty width; frame = 2^PWM_BITS ticks.
- `PRESCALE_BITS`, 16: width of the prescale input.
- `PERIOD_BITS`, 8: width of the per-channel blink/breathe step period.
- `hw_clk` in 1: single clock; all logic is rising-edge.
- `hw_rst` in 1: reset, asynchronous and active-high.
- `prescale` in PRESCALE_BITS: a tick occurs every `prescale`+1 clocks.
- `cfg_wr` in 1: single-cycle write strobe for channel config.
- `cfg_ch` in max(1,$clog2(CHANNELS)): target channel.
- `cfg_mode` in 2: 00 OFF, 01 STATIC, 10 BLINK, 11 BREATHE.
- `cfg_duty` in PWM_BITS: target duty (on-ticks per frame).
- `cfg_period` in PERIOD_BITS: frames per blink half-period / breathe step, minus 1.
- `pwm_out` out CHANNELS: registered PWM outputs.
- `frame_strobe` out 1: one-clock pulse on the clock where the PWM counter wraps.

## Operation
- Prescaler `pre_cnt`: a tick is generated when `pre_cnt >= prescale`, and `pre_cnt` clears to 0 on that clock; otherwise it increments. `prescale`=0 gives a tick every clock. Reducing `prescale` below the current count gives a tick on the next clock, so there is no 2^N stall.
- PWM counter `pwm_cnt` (PWM_BITS) increments per tick and wraps from all-ones to 0. The wrap tick is the frame boundary and raises `frame_strobe`.
- Shadow registers per channel hold mode, duty and period.
  - `cfg_wr` writes the shadow set selected by `cfg_ch`.
  - `cfg_ch >= CHANNELS` is ignored.
  - Active registers load from shadow only at a frame boundary, so a mid-frame write never produces a glitch or partial pulse.
  - Write on the same clock as the boundary: the new value is captured into shadow and becomes active at the next boundary.
- Each channel has a frame counter `fcnt` (PERIOD_BITS). At each boundary, if `fcnt == period` it clears and issues a step; otherwise it increments.
- Effective duty `eff` per mode:
  - OFF: `eff`=0.
  - STATIC: `eff`=duty.
  - BLINK: a phase bit toggles on each step; `eff`=duty when phase=1, else 0. The phase starts at 1 on entering BLINK.
  - BREATHE: `eff` moves ±1 per step as a triangle between 0 and duty. Direction reverses on reaching duty (up→down) or 0 (down→up).
    - If duty is lowered below the current `eff`, `eff` clamps to duty and the direction becomes down.
    - duty=0 holds `eff` at 0.
- A mode change, detected at the boundary load, resets `fcnt`, phase and direction (up). In BREATHE it also resets `eff` to 0.
- Output: `pwm_out[c]` is registered from (`pwm_cnt` < `eff[c]`). duty=0 is always low; the maximum duty is high for 2^PWM_BITS−1 of 2^PWM_BITS ticks.

## Timing
- Reset values:
  - `pwm_out`=0 and `frame_strobe`=0.
  - All counters, phases and `eff` values are 0.
  - All shadow and active modes are OFF with duty 0 and period 0.
  - Direction is up.
- Reset is asynchronous and takes effect mid-frame. The first tick after release occurs `prescale`+1 clocks after release.
- `pwm_out` lags the comparison by 1 clock, and `frame_strobe` is aligned with that same registered boundary.
- A config write is visible on `pwm_out` no earlier than the frame after the next boundary. That is the worst case of (2^PWM_BITS)·(`prescale`+1) + 1 clocks.
- STATIC output period = 2^PWM_BITS·(`prescale`+1) clocks.
- BLINK full period = 2·(period+1) frames.
- BREATHE full cycle = 2·duty·(period+1) frames.

## Test plan
- **Reset and idle.** Assert `hw_rst` mid-frame with all channels STATIC duty 128. Required: `pwm_out`=0 and `frame_strobe`=0 asynchronously; after release, no output until configured.
- **STATIC duty.** `prescale`=0, PWM_BITS=8, ch0 STATIC duty 64. Required: from the second frame, `pwm_out[0]` is high exactly 64 of every 256 clocks. Repeat with duty 0 (always low) and duty 255 (255/256 high).
- **Glitch-free update.** Write ch1 duty 200 at tick 100 of a frame running duty 50. Required: the current frame completes at 50; the next frame gives 200.
- **BLINK.** ch2 BLINK duty 255 with `cfg_period`=1. Required: PWM active for 2 frames, then low for 2 frames, repeating; phase starts on.
- **BREATHE.** ch0 BREATHE duty 4 with `cfg_period`=0. Required: `eff` per frame follows 0,1,2,3,4,3,2,1,0,1… Lowering duty to 2 while `eff`=3 gives 2 then 1.
- **Prescaler and invalid channel.** Change `prescale` from 1000 to 3 while `pre_cnt`=500: a tick occurs the next clock, then every 4 clocks. A write with `cfg_ch`=3 when CHANNELS=3 leaves all outputs unchanged.

Source files
------------

// File: rtl/rgb_pwm_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pwm_sequencer_if
//  Description : Configuration and output bundle of the RGB PWM sequencer.
//                master : drives prescale and the channel config write port,
//                         observes pwm_out / frame_strobe.
//                slave  : the sequencer itself.
//  Signals     : prescale     - tick every prescale+1 clocks
//                cfg_wr       - one-clock channel config write strobe
//                cfg_ch       - target channel (out-of-range writes ignored)
//                cfg_mode     - 00 OFF, 01 STATIC, 10 BLINK, 11 BREATHE
//                cfg_duty     - target duty (on-ticks per frame)
//                cfg_period   - frames per blink half-period / breathe step - 1
//                pwm_out      - registered PWM outputs, one per channel
//                frame_strobe - one-clock pulse at the PWM counter wrap
//  Revision    : 1.0 - initial release
// ============================================================================
interface rgb_pwm_sequencer_if #(
   parameter int CHANNELS      = 3,
   parameter int PWM_BITS      = 8,
   parameter int PRESCALE_BITS = 16,
   parameter int PERIOD_BITS   = 8
);
   localparam int c_CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [PRESCALE_BITS-1:0] prescale;
   logic                     cfg_wr;
   logic [c_CH_W-1:0]        cfg_ch;
   logic [1:0]               cfg_mode;
   logic [PWM_BITS-1:0]      cfg_duty;
   logic [PERIOD_BITS-1:0]   cfg_period;
   logic [CHANNELS-1:0]      pwm_out;
   logic                     frame_strobe;

   modport master (
      output prescale, cfg_wr, cfg_ch, cfg_mode, cfg_duty, cfg_period,
      input  pwm_out, frame_strobe
   );

   modport slave (
      input  prescale, cfg_wr, cfg_ch, cfg_mode, cfg_duty, cfg_period,
      output pwm_out, frame_strobe
   );
endinterface
`default_nettype wire

// File: rtl/rgb_pwm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pwm_sequencer
//  Description : Multi-channel LED PWM sequencer. A shared prescaler and PWM
//                frame counter feed per-channel pattern engines (OFF, STATIC,
//                BLINK, BREATHE). Channel config is double buffered: writes
//                land in shadow registers and go live only at a frame wrap,
//                so outputs never show a partial pulse.
//  Ports       : hw_clk - single rising-edge clock
//                hw_rst - asynchronous active-high reset
//                bus    - rgb_pwm_sequencer_if.slave (config in, PWM out)
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_pwm_sequencer #(
   parameter int CHANNELS      = 3,
   parameter int PWM_BITS      = 8,
   parameter int PRESCALE_BITS = 16,
   parameter int PERIOD_BITS   = 8
) (
   input  wire logic           hw_clk,
   input  wire logic           hw_rst,
   rgb_pwm_sequencer_if.slave  bus
);
   localparam int c_CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [1:0] c_MODE_OFF     = 2'b00;
   localparam logic [1:0] c_MODE_STATIC  = 2'b01;
   localparam logic [1:0] c_MODE_BLINK   = 2'b10;
   localparam logic [1:0] c_MODE_BREATHE = 2'b11;

   localparam logic [PWM_BITS-1:0] c_CNT_MAX = '1;

   logic [PRESCALE_BITS-1:0] r_pre_cnt;
   logic [PWM_BITS-1:0]      r_pwm_cnt;
   logic                     w_tick;
   logic                     w_boundary;
   logic [CHANNELS-1:0]      w_cmp;
   logic [CHANNELS-1:0]      r_pwm_out;
   logic                     r_frame_strobe;

   // ">=" rather than "==" so that lowering prescale below the running count
   // ticks on the next clock instead of waiting for the counter to wrap.
   assign w_tick     = (r_pre_cnt >= bus.prescale);
   assign w_boundary = w_tick && (r_pwm_cnt == c_CNT_MAX);

   always_ff @(posedge hw_clk or posedge hw_rst) begin
      if (hw_rst) begin
         r_pre_cnt <= '0;
         r_pwm_cnt <= '0;
      end else if (w_tick) begin
         r_pre_cnt <= '0;
         r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      end else begin
         r_pre_cnt <= r_pre_cnt + PRESCALE_BITS'(1);
      end
   end

   // ------------------------------------------------------------------------
   //  Per-channel pattern engine
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [1:0]             r_sh_mode;
      logic [PWM_BITS-1:0]    r_sh_duty;
      logic [PERIOD_BITS-1:0] r_sh_period;
      logic [1:0]             r_mode;
      logic [PWM_BITS-1:0]    r_duty;
      logic [PERIOD_BITS-1:0] r_period;
      logic [PERIOD_BITS-1:0] r_fcnt;
      logic                   r_phase;
      logic                   r_dir_down;
      logic [PWM_BITS-1:0]    r_eff;

      logic                   w_wr_hit;
      logic                   w_mode_chg;
      logic                   w_step;
      logic [PERIOD_BITS-1:0] w_fcnt_nxt;
      logic                   w_phase_nxt;
      logic                   w_dir_nxt;
      logic [PWM_BITS-1:0]    w_eff_nxt;

      // Channel numbers at or above CHANNELS never match any engine.
      assign w_wr_hit = bus.cfg_wr && (bus.cfg_ch == c_CH_W'(i));

      // Next-frame state, evaluated against the shadow set that is about to
      // become active. The step decision uses the period of the frame that
      // is ending.
      always_comb begin
         w_mode_chg  = (r_sh_mode != r_mode);
         w_step      = !w_mode_chg && (r_fcnt == r_period);
         w_fcnt_nxt  = (w_mode_chg || w_step) ? '0 : r_fcnt + PERIOD_BITS'(1);
         w_phase_nxt = w_mode_chg ? 1'b1 : r_phase;
         w_dir_nxt   = w_mode_chg ? 1'b0 : r_dir_down;
         w_eff_nxt   = '0;
         case (r_sh_mode)
            c_MODE_STATIC: begin
               w_eff_nxt = r_sh_duty;
            end
            c_MODE_BLINK: begin
               if (w_step) begin
                  w_phase_nxt = ~r_phase;
               end
               w_eff_nxt = w_phase_nxt ? r_sh_duty : '0;
            end
            c_MODE_BREATHE: begin
               w_eff_nxt = r_eff;
               if (w_mode_chg) begin
                  w_eff_nxt = '0;
               end else if (r_sh_duty < r_eff) begin
                  // Duty lowered under the current level: snap down and
                  // keep falling from there.
                  w_eff_nxt = r_sh_duty;
                  w_dir_nxt = 1'b1;
               end else if (w_step && (r_sh_duty != '0)) begin
                  if (!r_dir_down) begin
                     if (r_eff == r_sh_duty) begin
                        w_dir_nxt = 1'b1;
                        w_eff_nxt = r_eff - PWM_BITS'(1);
                     end else begin
                        w_eff_nxt = r_eff + PWM_BITS'(1);
                     end
                  end else begin
                     if (r_eff == '0) begin
                        w_dir_nxt = 1'b0;
                        w_eff_nxt = PWM_BITS'(1);
                     end else begin
                        w_eff_nxt = r_eff - PWM_BITS'(1);
                     end
                  end
               end
            end
            default: begin
               w_eff_nxt = '0;
            end
         endcase
      end

      always_ff @(posedge hw_clk or posedge hw_rst) begin
         if (hw_rst) begin
            r_sh_mode   <= c_MODE_OFF;
            r_sh_duty   <= '0;
            r_sh_period <= '0;
            r_mode      <= c_MODE_OFF;
            r_duty      <= '0;
            r_period    <= '0;
            r_fcnt      <= '0;
            r_phase     <= 1'b0;
            r_dir_down  <= 1'b0;
            r_eff       <= '0;
         end else begin
            // Active set loads the pre-write shadow, so a write coinciding
            // with the boundary takes effect one frame later.
            if (w_boundary) begin
               r_mode     <= r_sh_mode;
               r_duty     <= r_sh_duty;
               r_period   <= r_sh_period;
               r_fcnt     <= w_fcnt_nxt;
               r_phase    <= w_phase_nxt;
               r_dir_down <= w_dir_nxt;
               r_eff      <= w_eff_nxt;
            end
            if (w_wr_hit) begin
               r_sh_mode   <= bus.cfg_mode;
               r_sh_duty   <= bus.cfg_duty;
               r_sh_period <= bus.cfg_period;
            end
         end
      end

      assign w_cmp[i] = (r_pwm_cnt < r_eff);
   end : g_ch

   // frame_strobe is registered alongside pwm_out, so it marks the clock
   // that shows the last slot of the frame just ended.
   always_ff @(posedge hw_clk or posedge hw_rst) begin
      if (hw_rst) begin
         r_pwm_out      <= '0;
         r_frame_strobe <= 1'b0;
      end else begin
         r_pwm_out      <= w_cmp;
         r_frame_strobe <= w_boundary;
      end
   end

   assign bus.pwm_out      = r_pwm_out;
   assign bus.frame_strobe = r_frame_strobe;
endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_pwm_sequencer
//  Description : Self-checking bench for rgb_pwm_sequencer. A frame-level
//                integer reference model predicts pwm_out and frame_strobe
//                every clock; directed steps also measure on-ticks per frame
//                against hand-derived values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_pwm_sequencer;
   localparam int c_CH  = 3;
   localparam int c_MAX = 255;

   logic clk;
   logic rst;

   rgb_pwm_sequencer_if #(
      .CHANNELS(c_CH), .PWM_BITS(8), .PRESCALE_BITS(16), .PERIOD_BITS(8)
   ) bus ();

   rgb_pwm_sequencer #(
      .CHANNELS(c_CH), .PWM_BITS(8), .PRESCALE_BITS(16), .PERIOD_BITS(8)
   ) dut (
      .hw_clk (clk),
      .hw_rst (rst),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;
   int hi_cnt [c_CH];
   bit seen_strobe;

   // Reference model state (plain integers, frame-level rules)
   int m_pre, m_cnt;
   int sh_mode [c_CH], sh_duty [c_CH], sh_per [c_CH];
   int ac_mode [c_CH], ac_per [c_CH];
   int fcnt [c_CH], phase [c_CH], eff [c_CH], dir [c_CH];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pre = 0;
      m_cnt = 0;
      for (int c = 0; c < c_CH; c++) begin
         sh_mode[c] = 0; sh_duty[c] = 0; sh_per[c] = 0;
         ac_mode[c] = 0; ac_per[c] = 0;
         fcnt[c] = 0; phase[c] = 0; eff[c] = 0; dir[c] = 1;
      end
   endtask

   // Frame boundary: shadow becomes active, pattern advances one frame.
   task automatic frame_update(input int c);
      int  d;
      bit  chg;
      bit  stp;
      d   = sh_duty[c];
      chg = (sh_mode[c] != ac_mode[c]);
      stp = 0;
      if (chg) begin
         fcnt[c] = 0; phase[c] = 1; dir[c] = 1;
      end else if (fcnt[c] == ac_per[c]) begin
         fcnt[c] = 0; stp = 1;
      end else begin
         fcnt[c] = (fcnt[c] + 1) % 256;
      end
      case (sh_mode[c])
         1: eff[c] = d;
         2: begin
            if (stp) phase[c] = 1 - phase[c];
            eff[c] = (phase[c] != 0) ? d : 0;
         end
         3: begin
            if (chg) eff[c] = 0;
            else if (d < eff[c]) begin
               eff[c] = d; dir[c] = -1;
            end else if (stp && d > 0) begin
               if (dir[c] > 0 && eff[c] >= d) dir[c] = -1;
               else if (dir[c] < 0 && eff[c] <= 0) dir[c] = 1;
               eff[c] = eff[c] + dir[c];
            end
         end
         default: eff[c] = 0;
      endcase
      ac_mode[c] = sh_mode[c];
      ac_per[c]  = sh_per[c];
   endtask

   // One clock: predict, advance the model, clock the DUT, compare.
   task automatic step_clk();
      logic [31:0] e;
      bit tick, bnd;
      e = '0;
      if (rst) begin
         model_reset();
      end else begin
         tick = (m_pre >= int'(bus.prescale));
         bnd  = tick && (m_cnt == c_MAX);
         for (int c = 0; c < c_CH; c++) e[c] = (m_cnt < eff[c]);
         e[3] = bnd;
         if (bnd) for (int c = 0; c < c_CH; c++) frame_update(c);
         if (bus.cfg_wr && int'(bus.cfg_ch) < c_CH) begin
            sh_mode[bus.cfg_ch] = int'(bus.cfg_mode);
            sh_duty[bus.cfg_ch] = int'(bus.cfg_duty);
            sh_per[bus.cfg_ch]  = int'(bus.cfg_period);
         end
         if (tick) begin
            m_pre = 0;
            m_cnt = (m_cnt + 1) % 256;
         end else begin
            m_pre = m_pre + 1;
         end
      end
      @(posedge clk);
      #1;
      check("cycle_out", {28'd0, bus.frame_strobe, bus.pwm_out}, e);
      for (int c = 0; c < c_CH; c++) hi_cnt[c] += int'(bus.pwm_out[c]);
      seen_strobe = bus.frame_strobe;
   endtask

   task automatic write_cfg(input int ch, input int mode, input int duty, input int per);
      bus.cfg_ch     = 2'(ch);
      bus.cfg_mode   = 2'(mode);
      bus.cfg_duty   = 8'(duty);
      bus.cfg_period = 8'(per);
      bus.cfg_wr     = 1'b1;
      step_clk();
      bus.cfg_wr     = 1'b0;
   endtask

   task automatic wait_strobe();
      int k;
      int bound;
      k = 0;
      bound = 256 * (int'(bus.prescale) + 1) + 8;
      seen_strobe = 0;
      while (!seen_strobe && k < bound) begin
         step_clk();
         k++;
      end
      check("wait_strobe", {31'd0, seen_strobe}, 32'd1);
   endtask

   // Counts high clocks per channel over one full frame; optionally issues
   // a config write wr_at clocks into the frame.
   task automatic measure_frame(input int wr_at, input int wch, input int wmode,
                                input int wduty, input int wper);
      int k;
      int bound;
      k = 0;
      bound = 256 * (int'(bus.prescale) + 1) + 8;
      for (int c = 0; c < c_CH; c++) hi_cnt[c] = 0;
      seen_strobe = 0;
      while (!seen_strobe && k < bound) begin
         if (k == wr_at) write_cfg(wch, wmode, wduty, wper);
         else step_clk();
         k++;
      end
      check("frame_end", {31'd0, seen_strobe}, 32'd1);
   endtask

   initial begin
      int blink_exp [6];
      int br_exp [11];
      int n;
      int pick;

      blink_exp = '{255, 255, 0, 0, 255, 255};
      br_exp    = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2};

      rst = 1'b1;
      bus.prescale = '0;
      bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_mode = '0;
      bus.cfg_duty = '0; bus.cfg_period = '0;
      model_reset();
      repeat (3) step_clk();
      check("reset_out", {28'd0, bus.frame_strobe, bus.pwm_out}, 32'd0);
      rst = 1'b0;

      // All channels STATIC 128, then an asynchronous mid-frame reset
      for (int c = 0; c < c_CH; c++) write_cfg(c, 1, 128, 0);
      wait_strobe();
      measure_frame(-1, 0, 0, 0, 0);
      for (int c = 0; c < c_CH; c++) check($sformatf("pre_rst_ch%0d", c), hi_cnt[c], 128);
      repeat (50) step_clk();
      check("pre_rst_out", {29'd0, bus.pwm_out}, 32'd7);
      #2 rst = 1'b1;
      #1;
      check("async_rst_out", {28'd0, bus.frame_strobe, bus.pwm_out}, 32'd0);
      model_reset();
      repeat (2) step_clk();
      rst = 1'b0;
      wait_strobe();
      measure_frame(-1, 0, 0, 0, 0);
      for (int c = 0; c < c_CH; c++) check($sformatf("idle_ch%0d", c), hi_cnt[c], 0);

      // STATIC duty 64 / 0 / 255
      write_cfg(0, 1, 64, 0);
      write_cfg(1, 1, 0, 0);
      write_cfg(2, 1, 255, 0);
      wait_strobe();
      repeat (2) begin
         measure_frame(-1, 0, 0, 0, 0);
         check("static64", hi_cnt[0], 64);
         check("static0", hi_cnt[1], 0);
         check("static255", hi_cnt[2], 255);
      end

      // Glitch-free update on ch1: 50 -> 200 written at tick 100
      write_cfg(1, 1, 50, 0);
      wait_strobe();
      measure_frame(-1, 0, 0, 0, 0);
      check("glitch_before", hi_cnt[1], 50);
      measure_frame(100, 1, 1, 200, 0);
      check("glitch_same", hi_cnt[1], 50);
      measure_frame(-1, 0, 0, 0, 0);
      check("glitch_next", hi_cnt[1], 200);

      // BLINK ch2 duty 255 period 1
      write_cfg(2, 2, 255, 1);
      wait_strobe();
      for (int f = 0; f < 6; f++) begin
         measure_frame(-1, 0, 0, 0, 0);
         check($sformatf("blink_f%0d", f), hi_cnt[2], blink_exp[f]);
      end

      // BREATHE ch0 duty 4 period 0, then lower duty to 2 while eff=3
      write_cfg(0, 3, 4, 0);
      wait_strobe();
      for (int f = 0; f < 11; f++) begin
         measure_frame(-1, 0, 0, 0, 0);
         check($sformatf("breathe_f%0d", f), hi_cnt[0], br_exp[f]);
      end
      measure_frame(60, 0, 3, 2, 0);
      check("breathe_at3", hi_cnt[0], 3);
      measure_frame(-1, 0, 0, 0, 0);
      check("breathe_clamp", hi_cnt[0], 2);
      measure_frame(-1, 0, 0, 0, 0);
      check("breathe_down", hi_cnt[0], 1);

      // Prescaler 1000 -> 3 at pre_cnt = 500
      wait_strobe();
      bus.prescale = 16'd1000;
      repeat (500) step_clk();
      bus.prescale = 16'd3;
      n = 0;
      seen_strobe = 0;
      while (!seen_strobe && n < 2000) begin
         step_clk();
         n++;
      end
      check("prescale_wrap_clocks", n, 1021);
      measure_frame(-1, 0, 0, 0, 0);
      check("prescale_static200", hi_cnt[1], 800);

      // Invalid channel write leaves everything unchanged
      bus.prescale = 16'd0;
      write_cfg(0, 1, 10, 0);
      write_cfg(2, 1, 20, 0);
      wait_strobe();
      write_cfg(3, 1, 255, 0);
      wait_strobe();
      measure_frame(-1, 0, 0, 0, 0);
      check("inv_ch0", hi_cnt[0], 10);
      check("inv_ch1", hi_cnt[1], 200);
      check("inv_ch2", hi_cnt[2], 20);

      // Randomized config traffic against the model
      bus.prescale = 16'($urandom_range(0, 1));
      for (int i = 0; i < 8000; i++) begin
         if ($urandom_range(0, 1499) == 0) bus.prescale = 16'($urandom_range(0, 2));
         if ($urandom_range(0, 47) == 0) begin
            pick = int'($urandom_range(0, 5));
            case (pick)
               0: n = 0;
               1: n = 255;
               2: n = int'($urandom_range(1, 6));
               default: n = int'($urandom_range(0, 255));
            endcase
            write_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), n,
                      int'($urandom_range(0, 2)));
         end else begin
            step_clk();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
